// File: rtl/imem_read_arbiter.sv
// Two-port round-robin arbiter in front of the combinational instruction memory.
// Each port gets a bounded burst while the other port waits; read data is registered one cycle after grant.
module imem_read_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {NONE, OWN0, OWN1} state_t;
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic              g0, g1;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Owner keeps the port until its burst is spent, but only while the other side is waiting.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (m0_req && m1_req) begin
            case (state_q)
                OWN0:    if (burst_cnt_q < MAX_B) g0 = 1'b1; else g1 = 1'b1;
                OWN1:    if (burst_cnt_q < MAX_B) g1 = 1'b1; else g0 = 1'b1;
                default: if (last_q) g0 = 1'b1; else g1 = 1'b1;
            endcase
        end else begin
            g0 = m0_req;
            g1 = m1_req;
        end
    end

    assign m0_gnt   = g0 & rst_n;
    assign m1_gnt   = g1 & rst_n;
    assign mem_addr = g0 ? m0_addr : (g1 ? m1_addr : '0);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if (g0 || g1) begin
            if ((g0 && state_q == OWN0) || (g1 && state_q == OWN1)) begin
                if (burst_cnt_q < MAX_B) burst_cnt_d = burst_cnt_q + 4'd1;
            end else begin
                state_d     = g1 ? OWN1 : OWN0;
                burst_cnt_d = 4'd1;
                last_d      = g1;
            end
        end else begin
            state_d     = NONE;
            burst_cnt_d = 4'd0;
        end
    end

    // Response side: data and error flag hold between responses.
    always_comb begin
        rvalid0_d = g0;
        rvalid1_d = g1;
        rdata0_d  = g0 ? mem_rdata : rdata0_q;
        rdata1_d  = g1 ? mem_rdata : rdata1_q;
        err0_d    = g0 ? (m0_addr[1:0] != 2'b00) : err0_q;
        err1_d    = g1 ? (m1_addr[1:0] != 2'b00) : err1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NONE;
            last_q      <= 1'b1;
            burst_cnt_q <= 4'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m0_rdata  = rdata0_q;
    assign m0_err    = err0_q;
    assign m1_rvalid = rvalid1_q;
    assign m1_rdata  = rdata1_q;
    assign m1_err    = err1_q;

endmodule

// File: doc/imem_read_arbiter.md
Name: imem_read_arbiter

Overview:
- Shares the single combinational instruction-memory read port (8-bit byte address, 32-bit word) between two requesters: port 0 is core fetch, port 1 is the debug/boot-check reader.
- Grants one request per cycle using round-robin with a bounded burst, so each requester gets fair access.
- Returns registered read data one cycle after acceptance.
- Sits between the fetch logic and InstMem; InstMem itself is unchanged.

Parameters:
- ADDR_W, 8, byte address width; word index is addr[ADDR_W-1:2].
- DATA_W, 32, instruction word width.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other port is requesting (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- m0_req  input  1  port 0 read request
- m0_addr  input  ADDR_W  port 0 byte address
- m0_gnt  output  1  port 0 request accepted this cycle
- m0_rvalid  output  1  port 0 response valid
- m0_rdata  output  DATA_W  port 0 response word
- m0_err  output  1  port 0 response misaligned (addr[1:0]!=0)
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1
- mem_addr  output  ADDR_W  address to InstMem
- mem_rdata  input  DATA_W  InstMem combinational read data

Behaviour:
- Reset (async, rst_n low):
  - owner=NONE, last=M1 (port 0 wins the first tie), burst_cnt=0.
  - rvalid/rdata/err all 0.
  - gnt outputs forced 0 while rst_n low.
- FSM states: NONE, OWN0, OWN1. gnt and mem_addr are combinational from state, req and burst_cnt.
- Grant decision each cycle:
  - Only one port requesting: that port is granted.
  - Both requesting, state NONE: grant the port opposite to last.
  - Both requesting, state OWNx, burst_cnt < MAX_BURST: grant x.
  - Both requesting, state OWNx, burst_cnt == MAX_BURST: grant the other port.
  - Neither requesting: no grant, mem_addr=0.
- Acceptance is req&gnt at the clock edge; requester holds req and addr until granted. At most one gnt high per cycle.
- mem_addr = granted port's addr in the same cycle, passed through unmodified; InstMem ignores bits [1:0].
- Response latency is exactly 1 cycle:
  - At the accepting edge, mem_rdata is captured into the granted port's rdata.
  - err <= (addr[1:0]!=0); rvalid pulses high for one cycle.
  - The word at addr[7:2] is still returned on a misaligned access.
- Back-to-back: a port granted every cycle produces a continuous rvalid stream, one response per grant, in order.
- rdata holds its last value when rvalid is low. The other port's rvalid stays 0.
- State update on each accepted grant:
  - Grant to the current owner: burst_cnt += 1, saturating at MAX_BURST.
  - Grant to a new owner: state=OWNnew, burst_cnt=1, last=new.
- No grant in a cycle: state=NONE, burst_cnt=0 (last retained).
- Uncontested owner: burst_cnt saturates and the owner keeps its grant. The cap applies only when the other port requests.
- Owner drops req while the other requests: the other is granted that cycle; new owner, burst_cnt=1.
- Reset mid-operation clears any in-flight response (rvalid=0 immediately, asynchronously). The first post-reset tie goes to port 0.
- Address wrap: 0xFC is word 63; no overflow handling needed.

Test Plan:
- Single read: program image word1=0x00100093; m0_req=1, m0_addr=0x04 for one cycle -> m0_gnt=1 same cycle, mem_addr=0x04; next cycle m0_rvalid=1, m0_rdata=0x00100093, m0_err=0, m1_rvalid=0.
- Contention, MAX_BURST=4, both ports requesting continuously:
  - m0_addr=0x00, m1_addr=0x08 -> grant sequence 0,0,0,0,1,1,1,1,0...
  - m0_rdata=0x00007033, m1_rdata=0x00200113, each 1 cycle after its grant.
  - Never both gnt high.
- Uncontested burst: m0 requests 10 consecutive cycles, addr 0x00..0x24, m1 idle -> 10 grants, 10 in-order responses (word9=0x404404b3), burst_cnt saturates at 4.
- Owner release: m0 owns with burst_cnt=2 and drops req while m1 requests -> m1 granted that cycle. m0 re-requests next cycle with m1 still requesting -> m1 keeps the grant until burst_cnt=4.
- Misaligned: m1_addr=0x4B -> next cycle m1_rdata=word18=0x02b02823, m1_err=1.
- Reset mid-burst: assert rst_n low between a grant edge and its response -> rvalid=0 immediately. After release, with both requesting, port 0 is granted first.
